mem_dump_ctrl: RTL and testbench
================================

Name: mem_dump_ctrl

Overview:
- Parametrised successor to the single-pulse memory-dump counter and the top-level dump mux.
- Owns the shared-RAM address port: passes the CPU address and write enable through during normal run.
- During dump, walks a programmable address window [lo_addr, hi_addr] up or down, either per step pulse or on an auto-scan timer.
- Captures RAM read data for the display controller and blocks CPU writes while dumping.

Parameters:
ADDR_W, 8, RAM address width (256-deep RAM)
DATA_W, 16, RAM data width
AUTO_DIV, 500, clk cycles between auto-scan steps (1 s at 500 Hz); must be >= 2
DIV_W, 16, width of the auto-scan divider counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
dump_en  in  1  level; 1 = dump mode, 0 = CPU owns RAM
step  in  1  one-cycle pulse (from one_shot); advances pointer in manual mode
auto_en  in  1  level; 1 = auto-scan, step ignored
dir  in  1  0 = ascending, 1 = descending
lo_addr  in  ADDR_W  window start
hi_addr  in  ADDR_W  window end (inclusive)
cpu_addr  in  ADDR_W  CPU address
cpu_we  in  1  CPU write enable
mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
mem_addr  out  ADDR_W  address to RAM
mem_we  out  1  gated write enable to RAM
disp_word  out  ADDR_W+DATA_W  {ptr, captured data} to Display_Controller
dump_active  out  1  high in DUMP states
wrap  out  1  one-cycle pulse when the pointer wraps
range_err  out  1  high while lo_addr > hi_addr in dump mode

Behaviour:
- Reset (rst=0, async) clears ptr, divider, disp_word, wrap and range_err to 0 and sets state=RUN.
- States: RUN, LOAD, DUMP_MAN, DUMP_AUTO.
- RUN:
  - mem_addr = cpu_addr and mem_we = cpu_we, both combinational.
  - dump_active = 0.
  - dump_en=1 moves to LOAD.
- LOAD (1 cycle):
  - ptr <= lo_addr, divider cleared.
  - Next state is DUMP_AUTO if auto_en=1, else DUMP_MAN.
- DUMP_*:
  - mem_addr = ptr, mem_we = 0 regardless of cpu_we, dump_active = 1.
  - auto_en selects DUMP_MAN or DUMP_AUTO each cycle; switching modes does not reset ptr.
  - dump_en=0 returns to RUN the next cycle. ptr is held, but re-entry always goes through LOAD.
- Advance event:
  - DUMP_MAN: step=1.
  - DUMP_AUTO: divider reaches AUTO_DIV-1, then divider wraps to 0.
  - At most one advance per cycle; step is ignored in DUMP_AUTO.
- Advance arithmetic, mod 2^ADDR_W:
  - Ascending: ptr == hi_addr gives ptr <= lo_addr with wrap=1; otherwise ptr+1.
  - Descending: ptr == lo_addr gives ptr <= hi_addr with wrap=1; otherwise ptr-1.
  - lo_addr == hi_addr: ptr stays put and wrap pulses on every advance.
  - If lo/hi change and ptr falls outside the window, the next advance loads lo_addr (asc) or hi_addr (desc), with wrap=1.
- range_err:
  - lo_addr > hi_addr in a DUMP state sets range_err=1, forces ptr <= lo_addr and suppresses advances.
  - Clears once the window is valid.
- Display capture:
  - Every cycle, a registered copy of mem_addr (addr_d) is kept.
  - disp_word <= {addr_d, mem_rdata}, so displayed data always matches its address despite RAM latency.
  - Total latency from ptr change to disp_word update is 2 cycles.
  - Capture also runs in RUN, so the display shows CPU traffic.
- Reset mid-dump: ptr, divider, disp_word, wrap and range_err return to 0 and state to RUN; mem_we follows cpu_we immediately after release.

Decomposition:
- Shared package dump_pkg holds the state encoding (RUN=2'd0, LOAD=2'd1, DUMP_MAN=2'd2, DUMP_AUTO=2'd3) and default ADDR_W/DATA_W.
- One natural sub-module, window_ptr: the bounded up/down wrapping pointer with its range check (ptr, wrap, range_err).
- Divider and FSM stay in mem_dump_ctrl.

Test Plan:
- Reset: rst=0 with dump_en=1 and cpu_we=1 -> ptr=0, disp_word=0, dump_active=0; after release, mem_we=1 and mem_addr=cpu_addr.
- Manual ascending: lo=0x10, hi=0x12, dump_en=1, 4 step pulses -> mem_addr 0x10,0x11,0x12,0x10; wrap on the 3rd step; mem_we=0 while cpu_we=1.
- Descending from lo: lo=0x20, hi=0x22, dir=1, one step -> ptr=0x22, wrap=1 for one cycle.
- Auto scan: AUTO_DIV=4, lo=0, hi=0xFF, auto_en=1 -> ptr increments every 4 clk; step pulses ignored; 0xFF->0x00 with wrap.
- Capture alignment: RAM preloaded with mem[a]=a^16'hA5A5; step to 0x05 -> two cycles later disp_word={8'h05,16'hA5A0}.
- range_err and reset mid-dump: lo=0x30, hi=0x20 -> range_err=1, ptr=0x30, steps ignored; fix hi=0x40 -> range_err=0; then rst=0 mid-auto -> state RUN, ptr=0.

Source files
------------

// File: rtl/dump_pkg.sv
// dump_pkg: shared state encoding and default widths for the memory-dump controller
package dump_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD      = 2'd1,
        DUMP_MAN  = 2'd2,
        DUMP_AUTO = 2'd3
    } state_t;
endpackage

// File: rtl/window_ptr.sv
// window_ptr: bounded up/down wrapping pointer over [lo, hi] with range check
module window_ptr
    import dump_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              active,
    input  logic              adv,
    input  logic              dir,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap,
    output logic              range_err
);
    logic bad;
    logic restart;
    logic [ADDR_W-1:0] nxt;
    always_comb begin
        bad     = lo > hi;
        // An out-of-window pointer restarts at the entry edge, same as a normal wrap
        restart = (ptr < lo) || (ptr > hi) || (dir ? ptr == lo : ptr == hi);
        nxt     = restart ? (dir ? hi : lo) : (dir ? ptr - 1'b1 : ptr + 1'b1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            wrap      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            range_err <= active && bad;
            wrap      <= active && !bad && adv && restart;
            ptr       <= load || (active && bad) ? lo : active && adv ? nxt : ptr;
        end
    end
endmodule

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: shared-RAM address mux with windowed manual/auto memory dump and aligned display capture
module mem_dump_ctrl
    import dump_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AUTO_DIV = 500,
    parameter int DIV_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dump_en,
    input  logic                     step,
    input  logic                     auto_en,
    input  logic                     dir,
    input  logic [ADDR_W-1:0]        lo_addr,
    input  logic [ADDR_W-1:0]        hi_addr,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_we,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [ADDR_W+DATA_W-1:0] disp_word,
    output logic                     dump_active,
    output logic                     wrap,
    output logic                     range_err
);
    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] addr_d;
    logic              div_hit;
    logic              own;
    logic              adv;
    always_comb begin
        div_hit     = div == DIV_W'(AUTO_DIV - 1);
        dump_active = state == DUMP_MAN || state == DUMP_AUTO;
        // LOAD already owns the port so a CPU write cannot slip in on dump entry
        own         = state != RUN;
        mem_addr    = own ? ptr : cpu_addr;
        mem_we      = cpu_we && !own;
        adv         = (state == DUMP_MAN && step) || (state == DUMP_AUTO && div_hit);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            div       <= '0;
            addr_d    <= '0;
            disp_word <= '0;
        end else begin
            state     <= state == RUN ? (dump_en ? LOAD : RUN) :
                         !dump_en ? RUN : auto_en ? DUMP_AUTO : DUMP_MAN;
            div       <= state == LOAD ? '0 : state == DUMP_AUTO ? (div_hit ? '0 : div + 1'b1) : div;
            addr_d    <= mem_addr;
            disp_word <= {addr_d, mem_rdata};
        end
    end
    window_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == LOAD),
        .active   (dump_active),
        .adv      (adv),
        .dir      (dir),
        .lo       (lo_addr),
        .hi       (hi_addr),
        .ptr      (ptr),
        .wrap     (wrap),
        .range_err(range_err)
    );
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl: directed self-checking bench for mem_dump_ctrl
module tb_mem_dump_ctrl;
    logic        clk = 1'b0;
    logic        rst, dump_en, step, auto_en, dir, cpu_we;
    logic [7:0]  lo, hi, cpu_addr, mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_we, dump_active, wrap, range_err;
    logic [23:0] disp_word;
    logic [15:0] ram [256];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    mem_dump_ctrl #(.ADDR_W(8), .DATA_W(16), .AUTO_DIV(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .dump_en(dump_en), .step(step), .auto_en(auto_en), .dir(dir),
        .lo_addr(lo), .hi_addr(hi), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .disp_word(disp_word), .dump_active(dump_active),
        .wrap(wrap), .range_err(range_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic enter(input logic [7:0] l, input logic [7:0] h, input logic d, input logic a);
        dump_en = 1'b0;
        tick();
        lo = l; hi = h; dir = d; auto_en = a; dump_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; dump_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h5A;
        step = 1'b0; auto_en = 1'b0; dir = 1'b0; lo = 8'h00; hi = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dut.ptr !== 8'h00) begin fails++; $display("FAIL reset_ptr got %h exp 00", dut.ptr); end
        checks++; if (disp_word !== 24'h0) begin fails++; $display("FAIL reset_disp got %h exp 000000", disp_word); end
        checks++; if (dump_active !== 1'b0) begin fails++; $display("FAIL reset_active got %b exp 0", dump_active); end
        checks++; if ({wrap, range_err} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {wrap, range_err}); end
        dump_en = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (mem_we !== 1'b1) begin fails++; $display("FAIL release_we got %b exp 1", mem_we); end
        checks++; if (mem_addr !== 8'h5A) begin fails++; $display("FAIL release_addr got %h exp 5a", mem_addr); end
    endtask

    task automatic test_manual_asc();
        logic [7:0] exp_a [4] = '{8'h11, 8'h12, 8'h10, 8'h11};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        cpu_we = 1'b1;
        enter(8'h10, 8'h12, 1'b0, 1'b0);
        checks++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL asc_start got %h exp 10", mem_addr); end
        checks++; if ({mem_we, dump_active} !== 2'b01) begin fails++; $display("FAIL asc_gate got %b exp 01", {mem_we, dump_active}); end
        for (int i = 0; i < 4; i++) begin
            pulse();
            checks++; if (mem_addr !== exp_a[i]) begin fails++; $display("FAIL asc_step%0d got %h exp %h", i, mem_addr, exp_a[i]); end
            checks++; if (wrap !== exp_w[i]) begin fails++; $display("FAIL asc_wrap%0d got %b exp %b", i, wrap, exp_w[i]); end
        end
        dump_en = 1'b0;
        tick();
        checks++; if ({mem_we, dump_active} !== 2'b10) begin fails++; $display("FAIL asc_exit got %b exp 10", {mem_we, dump_active}); end
    endtask

    task automatic test_descending();
        enter(8'h20, 8'h22, 1'b1, 1'b0);
        pulse();
        checks++; if ({dut.ptr, wrap} !== {8'h22, 1'b1}) begin fails++; $display("FAIL desc_wrap got %h/%b exp 22/1", dut.ptr, wrap); end
        tick();
        checks++; if ({dut.ptr, wrap} !== {8'h22, 1'b0}) begin fails++; $display("FAIL desc_hold got %h/%b exp 22/0", dut.ptr, wrap); end
        pulse();
        checks++; if (dut.ptr !== 8'h21) begin fails++; $display("FAIL desc_dec got %h exp 21", dut.ptr); end
        lo = 8'h30; hi = 8'h38; dir = 1'b0;
        pulse();
        checks++; if ({dut.ptr, wrap} !== {8'h30, 1'b1}) begin fails++; $display("FAIL outwin got %h/%b exp 30/1", dut.ptr, wrap); end
        lo = 8'h40; hi = 8'h40;
        pulse();
        checks++; if ({dut.ptr, wrap} !== {8'h40, 1'b1}) begin fails++; $display("FAIL single_enter got %h/%b exp 40/1", dut.ptr, wrap); end
        pulse();
        checks++; if ({dut.ptr, wrap} !== {8'h40, 1'b1}) begin fails++; $display("FAIL single_stay got %h/%b exp 40/1", dut.ptr, wrap); end
    endtask

    task automatic test_auto();
        enter(8'h00, 8'hFF, 1'b0, 1'b1);
        checks++; if ({dut.ptr, dump_active} !== {8'h00, 1'b1}) begin fails++; $display("FAIL auto_start got %h/%b exp 00/1", dut.ptr, dump_active); end
        step = 1'b1;
        repeat (3) tick();
        step = 1'b0;
        checks++; if (dut.ptr !== 8'h00) begin fails++; $display("FAIL auto_step_ignored got %h exp 00", dut.ptr); end
        tick();
        checks++; if (dut.ptr !== 8'h01) begin fails++; $display("FAIL auto_first got %h exp 01", dut.ptr); end
        repeat (254 * 4) tick();
        checks++; if (dut.ptr !== 8'hFF) begin fails++; $display("FAIL auto_top got %h exp ff", dut.ptr); end
        repeat (3) tick();
        checks++; if ({dut.ptr, wrap} !== {8'hFF, 1'b0}) begin fails++; $display("FAIL auto_hold got %h/%b exp ff/0", dut.ptr, wrap); end
        tick();
        checks++; if ({mem_addr, wrap} !== {8'h00, 1'b1}) begin fails++; $display("FAIL auto_wrap got %h/%b exp 00/1", mem_addr, wrap); end
    endtask

    task automatic test_capture();
        enter(8'h03, 8'h08, 1'b0, 1'b0);
        pulse();
        pulse();
        checks++; if (mem_addr !== 8'h05) begin fails++; $display("FAIL cap_addr got %h exp 05", mem_addr); end
        tick();
        checks++; if (disp_word !== 24'h04A5A1) begin fails++; $display("FAIL cap_prev got %h exp 04a5a1", disp_word); end
        tick();
        checks++; if (disp_word !== 24'h05A5A0) begin fails++; $display("FAIL cap_align got %h exp 05a5a0", disp_word); end
        cpu_addr = 8'h77;
        dump_en = 1'b0;
        repeat (3) tick();
        checks++; if (disp_word !== 24'h77A5D2) begin fails++; $display("FAIL cap_run got %h exp 77a5d2", disp_word); end
    endtask

    task automatic test_range_err_reset();
        enter(8'h30, 8'h20, 1'b0, 1'b0);
        pulse();
        checks++; if ({range_err, dut.ptr} !== {1'b1, 8'h30}) begin fails++; $display("FAIL rerr_set got %b/%h exp 1/30", range_err, dut.ptr); end
        pulse();
        checks++; if ({dut.ptr, wrap} !== {8'h30, 1'b0}) begin fails++; $display("FAIL rerr_frozen got %h/%b exp 30/0", dut.ptr, wrap); end
        hi = 8'h40;
        tick();
        checks++; if ({range_err, dut.ptr} !== {1'b0, 8'h30}) begin fails++; $display("FAIL rerr_clear got %b/%h exp 0/30", range_err, dut.ptr); end
        pulse();
        checks++; if (dut.ptr !== 8'h31) begin fails++; $display("FAIL rerr_resume got %h exp 31", dut.ptr); end
        auto_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++; if ({dut.ptr, dump_active, wrap, range_err} !== 11'h0) begin fails++; $display("FAIL midreset got %h/%b%b%b exp 00/000", dut.ptr, dump_active, wrap, range_err); end
        checks++; if (disp_word !== 24'h0) begin fails++; $display("FAIL midreset_disp got %h exp 000000", disp_word); end
        dump_en = 1'b0; cpu_we = 1'b1; cpu_addr = 8'h9C;
        tick();
        rst = 1'b1;
        tick();
        checks++; if ({mem_we, mem_addr} !== {1'b1, 8'h9C}) begin fails++; $display("FAIL postreset got %b/%h exp 1/9c", mem_we, mem_addr); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 16'(a) ^ 16'hA5A5;
        test_reset();
        test_manual_asc();
        test_descending();
        test_auto();
        test_capture();
        test_range_err_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
